// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - transmit-side 8N1 UART fed from a synchronous word FIFO
module fifo_uart_tx #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int DIVISOR = 86,
  parameter int LEVEL   = 2
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_w_en,
  input  logic [WIDTH-1:0] i_w_data,
  output logic             o_tx,
  output logic             o_full,
  output logic             o_afull,
  output logic             o_empty,
  output logic             o_aempty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DIVISOR);
  localparam int XW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    baud_cnt;
  logic [XW-1:0]    bit_idx;
  logic             wr_ok;
  logic             pop;
  logic             tick;

  // A write while full is dropped even if the transmitter pops on the same edge.
  assign wr_ok = i_w_en & ~o_full;
  assign tick  = (baud_cnt == BW'(DIVISOR - 1));

  // Transmitter state register; reset forces IDLE so o_tx returns high at once.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state, pop request and serial output; STOP chains straight into START when more data waits.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    o_tx     = 1'b1;
    case (state)
      IDLE: begin
        if (i_enable && !o_empty) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        o_tx = 1'b0;
        if (tick) state_nx = DATA;
      end
      DATA: begin
        o_tx = shreg[0];
        if (tick && bit_idx == XW'(WIDTH - 1)) state_nx = STOP;
      end
      STOP: begin
        if (tick) begin
          if (i_enable && !o_empty) begin
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit timer and shift register; the timer restarts on every pop so each bit is exactly DIVISOR clocks.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (pop) begin
      shreg    <= mem[rd_ptr];
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
      if (state == DATA && tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Occupancy after this edge; write and pop together leave it unchanged.
  always_comb begin
    count_nx = count;
    case ({wr_ok, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  // Pointers, count and registered level flags; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_full   <= 1'b0;
      o_afull  <= 1'b0;
      o_empty  <= 1'b1;
      o_aempty <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nx;
      o_full   <= (count_nx == CW'(DEPTH));
      o_afull  <= (count_nx >= CW'(DEPTH - LEVEL));
      o_empty  <= (count_nx == '0);
      o_aempty <= (count_nx <= CW'(LEVEL));
    end
  end

  // Word storage; no reset needed since contents are only read when count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= i_w_data;
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench for fifo_uart_tx with a serial receiver model
module tb_fifo_uart_tx;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int DIVISOR = 86;
  localparam int LEVEL   = 2;
  localparam int FRAME   = (WIDTH + 2) * DIVISOR;

  logic             clk      = 1'b0;
  logic             i_reset  = 1'b0;
  logic             i_enable = 1'b0;
  logic             i_w_en   = 1'b0;
  logic [WIDTH-1:0] i_w_data = '0;
  logic             o_tx;
  logic             o_full;
  logic             o_afull;
  logic             o_empty;
  logic             o_aempty;

  int               n_checks   = 0;
  int               n_fail     = 0;
  int               cyc        = 0;
  int               prev_start = 0;
  int               lvl;
  int               lows;
  bit               rx_on      = 1'b1;
  bit               gap_check  = 1'b0;
  bit               have_prev  = 1'b0;
  logic [WIDTH-1:0] sb [$];

  fifo_uart_tx #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .DIVISOR (DIVISOR),
    .LEVEL   (LEVEL)
  ) dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_w_en   (i_w_en),
    .i_w_data (i_w_data),
    .o_tx     (o_tx),
    .o_full   (o_full),
    .o_afull  (o_afull),
    .o_empty  (o_empty),
    .o_aempty (o_aempty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_flags(input int n);
    check_eq("o_empty",  {31'd0, o_empty},  {31'd0, n == 0});
    check_eq("o_aempty", {31'd0, o_aempty}, {31'd0, n <= LEVEL});
    check_eq("o_afull",  {31'd0, o_afull},  {31'd0, n >= DEPTH - LEVEL});
    check_eq("o_full",   {31'd0, o_full},   {31'd0, n == DEPTH});
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [WIDTH-1:0] d, input bit accept);
    i_w_en   = 1'b1;
    i_w_data = d;
    if (accept) sb.push_back(d);
    @(negedge clk);
    i_w_en = 1'b0;
  endtask

  task automatic wait_start(input int bound);
    int k = 0;
    while (o_tx !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check_eq("start_timeout", {31'd0, o_tx}, 32'd0);
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_timeout", sb.size(), 32'd0);
  endtask

  // Receiver: detect the start edge, sample each bit mid-period, compare against the scoreboard.
  initial begin
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] exp;
    int               st;
    forever begin
      @(negedge clk);
      if (i_reset && o_tx === 1'b0) begin
        st = cyc;
        if (gap_check && have_prev && rx_on)
          check_eq("frame_gap", st - prev_start, FRAME);
        prev_start = st;
        have_prev  = 1'b1;
        repeat (DIVISOR / 2) @(negedge clk);
        if (rx_on) check_eq("start_bit", {31'd0, o_tx}, 32'd0);
        for (int i = 0; i < WIDTH; i++) begin
          repeat (DIVISOR) @(negedge clk);
          rb[i] = o_tx;
        end
        repeat (DIVISOR) @(negedge clk);
        if (rx_on) begin
          check_eq("stop_bit", {31'd0, o_tx}, 32'd1);
          exp = (sb.size() > 0) ? sb.pop_front() : ~rb;
          check_eq("rx_data", {24'd0, rb}, {24'd0, exp});
        end
      end
    end
  end

  initial begin
    logic [8:0] pat;

    // Reset state
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_tx", {31'd0, o_tx}, 32'd1);
    check_flags(0);
    i_reset = 1'b1;
    @(negedge clk);

    // Fill with transmit disabled, then send 8 back-to-back frames
    gap_check = 1'b1;
    have_prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pat = (9'd1 << (k + 1)) - 9'd1;
      wr(pat[7:0], 1'b1);
      check_flags(k + 1);
      check_eq("idle_tx", {31'd0, o_tx}, 32'd1);
    end
    i_enable = 1'b1;
    wait_drain(9 * FRAME);
    repeat (DIVISOR) @(negedge clk);
    check_eq("p1_tx", {31'd0, o_tx}, 32'd1);
    check_eq("p1_empty", {31'd0, o_empty}, 32'd1);

    // Disable during frame 3, hold idle for 40 bit periods, then resume
    i_enable  = 1'b0;
    gap_check = 1'b0;
    have_prev = 1'b0;
    for (int k = 0; k < 8; k++) wr(8'($urandom_range(0, 255)), 1'b1);
    i_enable = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      wait_start(2 * FRAME);
      if (f < 3) repeat (FRAME) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    i_enable = 1'b0;
    repeat (FRAME - 100) @(negedge clk);
    lows = 0;
    for (int k = 0; k < 40 * DIVISOR; k++) begin
      if (o_tx !== 1'b1) lows++;
      @(negedge clk);
    end
    check_eq("disabled_idle", lows, 32'd0);
    check_eq("words_held", {31'd0, o_empty}, 32'd0);
    check_eq("sb_left", sb.size(), 32'd5);
    i_enable = 1'b1;
    wait_drain(7 * FRAME);
    repeat (DIVISOR) @(negedge clk);
    check_eq("p2_empty", {31'd0, o_empty}, 32'd1);

    // Overflow: 20 writes, only the first DEPTH are kept
    i_enable = 1'b0;
    lvl = 0;
    for (int k = 0; k < 20; k++) begin
      wr(8'(8'h40 + k), lvl < DEPTH);
      if (lvl < DEPTH) lvl++;
      check_flags(lvl);
    end
    gap_check = 1'b1;
    have_prev = 1'b0;
    i_enable  = 1'b1;
    wait_drain(17 * FRAME);
    repeat (DIVISOR) @(negedge clk);
    check_eq("p3_empty", {31'd0, o_empty}, 32'd1);
    check_eq("p3_tx", {31'd0, o_tx}, 32'd1);

    // Wrap: a write lands on every frame-boundary pop edge, occupancy stays at LEVEL+1
    i_enable  = 1'b0;
    have_prev = 1'b0;
    for (int k = 0; k < LEVEL + 2; k++) wr(8'($urandom_range(0, 255)), 1'b1);
    i_enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wait_start(2 * FRAME);
      repeat (FRAME - 1) @(negedge clk);
      wr(8'($urandom_range(0, 255)), 1'b1);
      check_eq("wrap_aempty", {31'd0, o_aempty}, 32'd0);
      check_eq("wrap_empty", {31'd0, o_empty}, 32'd0);
    end
    wait_drain(6 * FRAME);
    repeat (DIVISOR) @(negedge clk);
    check_eq("p4_empty", {31'd0, o_empty}, 32'd1);

    // Reset in the middle of a frame
    gap_check = 1'b0;
    wr(8'h5A, 1'b1);
    wait_start(2 * FRAME);
    repeat (300) @(negedge clk);
    rx_on = 1'b0;
    sb.delete();
    i_reset = 1'b0;
    #1;
    check_eq("midrst_tx", {31'd0, o_tx}, 32'd1);
    check_flags(0);
    @(negedge clk);
    i_reset = 1'b1;
    repeat (FRAME + DIVISOR) @(negedge clk);
    check_eq("post_rst_tx", {31'd0, o_tx}, 32'd1);
    check_eq("post_rst_empty", {31'd0, o_empty}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Transmit-side UART with an input FIFO. Upstream logic pushes WIDTH-bit words into a synchronous FIFO. When the block is enabled, a transmitter pops the words one at a time and serialises each as an 8N1-style frame on o_tx. FIFO level flags (full, almost-full, empty, almost-empty) are exported for upstream flow control.

Parameters:
- WIDTH, 8: data word width in bits; also the number of data bits per frame.
- DEPTH, 16: FIFO depth in words; must be a power of two and at least 4.
- DIVISOR, 86: system clocks per UART bit; must be even. 86 gives roughly 115200 baud at 10 MHz.
- LEVEL, 2: threshold for the almost-full and almost-empty flags; must satisfy 1 <= LEVEL < DEPTH/2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_enable  in  1  transmit enable; when low, no new frame is started.
- i_w_en  in  1  FIFO write strobe.
- i_w_data  in  WIDTH  FIFO write data.
- o_tx  out  1  UART serial output; idles high.
- o_full  out  1  FIFO count == DEPTH.
- o_afull  out  1  FIFO count >= DEPTH-LEVEL.
- o_empty  out  1  FIFO count == 0.
- o_aempty  out  1  FIFO count <= LEVEL.

Behaviour:
- Reset (i_reset low, asynchronous):
  - Read pointer, write pointer and count cleared; transmitter goes to IDLE.
  - o_tx=1, o_empty=1, o_aempty=1, o_full=0, o_afull=0.
  - A reset mid-frame aborts the frame; o_tx goes high immediately.
  - Internal state leaves reset synchronously on the first clk edge after release.
- FIFO storage and count:
  - Circular buffer with pointers of width clog2(DEPTH); pointers wrap from DEPTH-1 to 0.
  - Count is clog2(DEPTH)+1 bits wide.
- Write: on a clk edge with i_w_en=1 and o_full=0, i_w_data is stored and the write pointer advances. A write while full is dropped silently, even if a pop occurs in the same cycle.
- Pop: performed only by the transmitter, and only when count != 0.
- Simultaneous accepted write and pop: count unchanged; both pointers advance.
- Flags: registered, and they reflect count after each edge.
- Transmitter FSM states are IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If i_enable=1 and o_empty=0 at an edge, pop the head word into the shift register and go to START. The first word is popped on the cycle it is at the head.
  - START: o_tx=0 for DIVISOR clocks. o_tx falls on the clock after the pop.
  - DATA: WIDTH bits, LSB first, each held for DIVISOR clocks.
  - STOP: o_tx=1 for DIVISOR clocks. At the last stop clock, if i_enable=1 and the FIFO is non-empty, pop the next word and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Bit timing: a clock-enable counter counts 0..DIVISOR-1. It is cleared on frame start, so each bit is exactly DIVISOR clocks. One frame lasts (WIDTH+2)*DIVISOR clocks.
- i_enable deassertion: a frame already in progress always completes. Words stay in the FIFO, and writes are still accepted. Re-asserting i_enable resumes transmission with the next word, in order.
- Data integrity: words are transmitted in write order with no loss or duplication, provided no write occurs while full.

Test Plan:
- Reset: drive i_reset low for 2 clocks -> o_tx=1, o_empty=1, o_aempty=1, o_full=0, o_afull=0. Drive i_reset low mid-frame -> o_tx=1 within the same cycle, FIFO empty.
- Fill with i_enable=0: write 8 words (0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF) -> o_empty falls after the 1st write, o_aempty falls after the 3rd, o_afull=0, o_full=0, o_tx stays 1.
- Enable: assert i_enable -> 8 back-to-back frames, each 10*86 clocks. Each frame is a start bit 0, 8 bits LSB first matching the write order, then a stop bit 1. Afterwards o_empty=1 and o_tx=1.
- Disable mid-stream: deassert i_enable during frame 3 -> frame 3 completes, o_tx then stays 1 for 40 bit periods. Re-assert -> frames 4..8 follow in order.
- Overflow: write 20 words with i_enable=0 -> o_afull=1 at count 14, o_full=1 at count 16, words 17..20 dropped. Draining the FIFO yields exactly words 1..16.
- Wrap and simultaneous access: with i_enable=1, keep writing at one word per frame across more than 2*DEPTH words -> pointers wrap, no corruption, and the count is unchanged on cycles with both a write and a pop.
